// File: rtl/memory_writeback_stage.sv
// Memory/write-back pipeline stage: word-addressed data memory with
// combinational read, fault detection on misaligned or out-of-range
// accesses, MEM/WB pipeline register, sticky error capture and a
// committed-store counter.
module memory_writeback_stage #(
   parameter int unsigned DEPTH_LOG2 = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWM,
   input  logic        MemToRegM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  WriteRegM,
   input  logic        ErrClr,
   output logic [31:0] ReadDataM,
   output logic        RegWW,
   output logic        MemToRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [4:0]  WriteRegW,
   output logic [31:0] ResultW,
   output logic        ErrFlag,
   output logic [31:0] ErrAddr,
   output logic [15:0] StoreCount
);

   localparam int unsigned WORDS = 1 << DEPTH_LOG2;

   logic                  access;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  fault;
   logic                  store_commit;
   logic [DEPTH_LOG2-1:0] word_idx;

   logic [31:0] mem_q [WORDS];
   logic [31:0] mem_d [WORDS];

   logic        reg_w_q,      reg_w_d;
   logic        mem_to_reg_q, mem_to_reg_d;
   logic [31:0] read_data_q,  read_data_d;
   logic [31:0] alu_out_q,    alu_out_d;
   logic [4:0]  write_reg_q,  write_reg_d;
   logic        err_flag_q,   err_flag_d;
   logic [31:0] err_addr_q,   err_addr_d;
   logic [15:0] store_cnt_q,  store_cnt_d;

   // Address decode and fault classification for the current access
   always_comb begin
      access       = MemWriteM | MemToRegM;
      misaligned   = |ALUOutM[1:0];
      out_of_range = |ALUOutM[31:DEPTH_LOG2+2];
      fault        = access & (misaligned | out_of_range);
      word_idx     = ALUOutM[DEPTH_LOG2+1:2];
      store_commit = MemWriteM & ~fault;
   end

   // Combinational read; a faulting access returns zero
   always_comb begin
      ReadDataM = fault ? '0 : mem_q[word_idx];
   end

   // Next memory contents: only a committed store modifies one word
   always_comb begin
      mem_d = mem_q;
      if (store_commit) begin
         mem_d[word_idx] = WriteDataM;
      end
   end

   // Memory array; reset clears every word asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Next-state for the MEM/WB register, sticky error and store counter
   always_comb begin
      reg_w_d      = RegWM & ~fault;
      mem_to_reg_d = MemToRegM;
      read_data_d  = ReadDataM;
      alu_out_d    = ALUOutM;
      write_reg_d  = WriteRegM;

      err_flag_d   = err_flag_q;
      err_addr_d   = err_addr_q;
      // A fault coinciding with ErrClr re-arms the capture with the new address
      if (fault && (ErrClr || !err_flag_q)) begin
         err_flag_d = 1'b1;
         err_addr_d = ALUOutM;
      end else if (ErrClr && !fault) begin
         err_flag_d = 1'b0;
         err_addr_d = '0;
      end

      store_cnt_d  = store_cnt_q;
      if (store_commit) begin
         store_cnt_d = store_cnt_q + 16'd1;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_w_q      <= 1'b0;
         mem_to_reg_q <= 1'b0;
         read_data_q  <= '0;
         alu_out_q    <= '0;
         write_reg_q  <= '0;
         err_flag_q   <= 1'b0;
         err_addr_q   <= '0;
         store_cnt_q  <= '0;
      end else begin
         reg_w_q      <= reg_w_d;
         mem_to_reg_q <= mem_to_reg_d;
         read_data_q  <= read_data_d;
         alu_out_q    <= alu_out_d;
         write_reg_q  <= write_reg_d;
         err_flag_q   <= err_flag_d;
         err_addr_q   <= err_addr_d;
         store_cnt_q  <= store_cnt_d;
      end
   end

   // Output mapping and write-back result select
   always_comb begin
      RegWW      = reg_w_q;
      MemToRegW  = mem_to_reg_q;
      ReadDataW  = read_data_q;
      ALUOutW    = alu_out_q;
      WriteRegW  = write_reg_q;
      ErrFlag    = err_flag_q;
      ErrAddr    = err_addr_q;
      StoreCount = store_cnt_q;
      ResultW    = mem_to_reg_q ? read_data_q : alu_out_q;
   end

endmodule
